uart_rx_deframer: RTL and testbench

Receive-side framing engine of the UART RX path. Consumes the oversampling tick produced by the RX baud generator, synchronises the serial line, detects and validates the start bit, shifts in LSB-first data, checks the stop bit, and presents each received byte with a one-cycle valid strobe and error flags. It sits directly downstream of the RX baud generator and upstream of any RX buffering or host logic.

---
 rtl/uart_rx_deframer.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: receive-side UART framing engine.
// Synchronises rx_in, validates the start bit at its midpoint, shifts in
// LSB-first data on baud_tick-paced mid-bit samples, checks the stop bit and
// presents each word with a one-cycle data_valid strobe plus error flags.
//
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   baud_tick     - single-cycle enable, OVERSAMPLE x bit rate
//   rx_in         - asynchronous serial line, idles high
//   data_out      - last received data word (held until next strobe)
//   data_valid    - one-cycle strobe when data_out and flags update
//   frame_err     - stop bit sampled low on the last frame
//   parity_err    - even-parity mismatch on the last frame
//   busy          - high whenever the receiver is not idle
//
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit
// between the data bits and the stop bit; otherwise parity_err is tied to 0.
module uart_rx_deframer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
`endif

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_in};
  end
  assign rx_s = sync_q[1];

  // Next-state, counters, shift register and registered output values.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
`endif
    if (baud_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            tick_cnt_d = '0;
            state_d    = S_START;
          end
        end
        S_START: begin
          if (tick_cnt_q == TICK_MID) begin
            // Start bit must still be low at its midpoint, else false start.
            if (!rx_s) begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            par_bit_d  = rx_s;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            data_d     = shift_q;
            valid_d    = 1'b1;
            ferr_d     = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d     = (^shift_q) ^ par_bit_q;
`endif
            // A low stop bit may be a break; wait for the line to recover.
            state_d    = rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer (DATA_BITS=8, OVERSAMPLE=16,
// baud_tick every 4 clk). Frames are built bit by bit from the serial
// framing rules; expected records come from a frame-level reference model.
module tb_uart_rx_deframer;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rx_in = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid, frame_err, parity_err, busy;

  int checks = 0;
  int failures = 0;

  // Record layout: {frame_err, parity_err, data}
  logic [DB+1:0] got_q[$];
  logic [DB+1:0] exp_q[$];
  logic [1:0]    div = 2'd0;

  uart_rx_deframer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx_in),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Tick every 4th clk; changes on the falling edge so it is stable at posedge.
  always @(negedge clk) begin
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  // Capture every strobe cycle away from the active edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) got_q.push_back({frame_err, parity_err, data_out});
  end

  function automatic logic [DB+1:0] model(input logic [DB-1:0] d, input logic pbit,
                                          input logic stop);
    logic perr;
`ifdef UART_RX_PARITY_EN
    perr = (^d) ^ pbit;
`else
    perr = 1'b0;
`endif
    return {~stop, perr, d};
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit);
`endif
    drive_bit(stop);
  endtask

  task automatic check_records(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s strobe count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s record %0d {ferr,perr,data}: got %0h expected %0h",
                 name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({data_out, data_valid, frame_err, parity_err, busy} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got %0h expected 0",
               {data_out, data_valid, frame_err, parity_err, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);
    check_bit("idle busy after reset", busy, 1'b0);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL idle strobe after reset: got %0d expected 0", got_q.size());
    end
  endtask

  task automatic test_nominal();
    send_frame(8'hA5, ^8'hA5, 1'b1);
    exp_q.push_back(model(8'hA5, ^8'hA5, 1'b1));
    rx_in = 1'b1;
    wait_ticks(4);
    check_bit("nominal busy after frame", busy, 1'b0);
    check_records("nominal");
  endtask

  task automatic test_glitch();
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(2);
    check_bit("glitch busy during start", busy, 1'b1);
    wait_ticks(6);
    check_bit("glitch busy after reject", busy, 1'b0);
    wait_ticks(8);
    check_records("glitch");
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    exp_q.push_back(model(8'h3C, ^8'h3C, 1'b0));
    rx_in = 1'b0;
    wait_ticks(40);
    check_bit("break busy while held low", busy, 1'b1);
    rx_in = 1'b1;
    wait_ticks(4);
    check_bit("break busy after release", busy, 1'b0);
    check_records("frame_error");
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    rx_in = 1'b1;
    wait_ticks(4);
    check_bit("parity 0x03/1 perr", parity_err, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    rx_in = 1'b1;
    wait_ticks(4);
    check_bit("parity 0x03/0 perr", parity_err, 1'b0);
    exp_q.push_back(model(8'h03, 1'b1, 1'b1));
    exp_q.push_back(model(8'h03, 1'b0, 1'b1));
    check_records("parity");
`endif
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    exp_q.push_back(model(8'h00, 1'b0, 1'b1));
    exp_q.push_back(model(8'hFF, 1'b0, 1'b1));
    rx_in = 1'b1;
    wait_ticks(8);
    check_records("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    logic [DB-1:0] d;
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_in = d[4];
    wait_ticks(8);
    check_bit("midframe busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, frame_err, parity_err, busy} !== '0) begin
      failures++;
      $display("FAIL midframe reset outputs: got %0h expected 0",
               {data_out, data_valid, frame_err, parity_err, busy});
    end
    rx_in = 1'b1;
    wait_ticks(2);
    rst_n = 1'b1;
    wait_ticks(40);
    check_records("partial frame");
    send_frame(8'h5A, ^8'h5A, 1'b1);
    exp_q.push_back(model(8'h5A, ^8'h5A, 1'b1));
    rx_in = 1'b1;
    wait_ticks(4);
    checks++;
    if (data_out !== 8'h5A) begin
      failures++;
      $display("FAIL post-reset data_out: got %0h expected 5a", data_out);
    end
    check_records("post-reset frame");
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    logic pbit, stop;
    for (int n = 0; n < 16; n++) begin
      d    = DB'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, pbit, stop);
      exp_q.push_back(model(d, pbit, stop));
      rx_in = 1'b1;
      if (!stop) wait_ticks(OS);
      wait_ticks($urandom_range(0, 3));
    end
    rx_in = 1'b1;
    wait_ticks(20);
    check_bit("random busy at end", busy, 1'b0);
    check_records("random");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_frame_error();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
